// File: rtl/control_seq_pkg.sv
// control_seq_pkg: shared ISA opcodes, FSM states and datapath select encodings
package control_seq_pkg;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, LOAD_MEM, STORE_MEM, TRAP, HALTED
    } state_t;

    localparam logic ADDR_ALU = 1'b0;
    localparam logic ADDR_PC  = 1'b1;
    localparam logic RD_ALU   = 1'b0;
    localparam logic RD_MEM   = 1'b1;

    localparam logic [1:0] IN1_RS   = 2'b00;
    localparam logic [1:0] IN1_PC   = 2'b01;
    localparam logic [1:0] IN1_ZERO = 2'b11;
    localparam logic [1:0] IN2_RS   = 2'b00;
    localparam logic [1:0] IN2_IMM  = 2'b01;
    localparam logic [1:0] IN2_FOUR = 2'b11;

    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_MISCMEM = 5'b00011;
    localparam logic [4:0] OP_OPIMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_OP      = 5'b01100;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;

    function automatic logic is_exec(input logic [4:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_OPIMM, OP_OP, OP_MISCMEM, OP_SYSTEM};
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM, OP_OP};
    endfunction

endpackage

// File: rtl/control_seq_retire_counter.sv
// retire_counter: wrapping count of retired instructions
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (inc) count <= count + CNT_W'(1);
endmodule

// File: rtl/control_seq.sv
// control_seq: multi-cycle RV32 control FSM with debug halt/step/resume
module control_seq
    import control_seq_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int DEBUG_EN        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             mem_done,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    output logic             write_pc,
    output logic             write_ir,
    output logic             write_rd,
    output logic             mem_read,
    output logic             mem_write,
    output logic             addr_sel,
    output logic             rd_sel,
    output logic [1:0]       alu_insel1,
    output logic [1:0]       alu_insel2,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    localparam bit DBG    = DEBUG_EN != 0;
    localparam bit HALT_I = HALT_ON_ILLEGAL != 0;

    state_t state, state_nx;
    logic   step_pending, retire;

    always_ff @(posedge clk)
        if (rst) begin
            state        <= FETCH;
            step_pending <= 1'b0;
        end else begin
            state        <= state_nx;
            step_pending <= (state == HALTED && DBG && step_req && !resume_req) ? 1'b1 :
                            (retire || state == TRAP) ? 1'b0 : step_pending;
        end

    always_comb begin
        state_nx   = state;
        write_pc   = 1'b0;
        write_ir   = 1'b0;
        write_rd   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = ADDR_ALU;
        rd_sel     = RD_ALU;
        alu_insel1 = IN1_RS;
        alu_insel2 = IN2_RS;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                addr_sel = ADDR_PC;
                write_ir = mem_done;
                state_nx = mem_done ? DECODE : FETCH;
            end
            DECODE: state_nx = opcode == OP_LOAD  ? LOAD_MEM :
                               opcode == OP_STORE ? STORE_MEM :
                               is_exec(opcode)    ? EXEC : TRAP;
            EXEC: begin
                write_pc   = 1'b1;
                write_rd   = writes_rd(opcode);
                alu_insel1 = opcode == OP_LUI ? IN1_ZERO :
                             opcode inside {OP_AUIPC, OP_JAL, OP_JALR} ? IN1_PC : IN1_RS;
                alu_insel2 = opcode inside {OP_JAL, OP_JALR} ? IN2_FOUR :
                             opcode inside {OP_LUI, OP_AUIPC, OP_OPIMM} ? IN2_IMM : IN2_RS;
            end
            LOAD_MEM: begin
                mem_read   = 1'b1;
                alu_insel2 = IN2_IMM;
                write_rd   = mem_done;
                rd_sel     = mem_done ? RD_MEM : RD_ALU;
                write_pc   = mem_done;
            end
            STORE_MEM: begin
                mem_write  = 1'b1;
                alu_insel2 = IN2_IMM;
                write_pc   = mem_done;
            end
            TRAP: begin
                illegal  = 1'b1;
                write_pc = !HALT_I;
                state_nx = HALT_I ? HALTED : FETCH;
            end
            HALTED: begin
                halted   = 1'b1;
                state_nx = DBG && (resume_req || step_req) ? FETCH : HALTED;
            end
            default: state_nx = FETCH;
        endcase
        retire = write_pc && state != TRAP;
        if (retire) state_nx = (DBG && halt_req) || step_pending ? HALTED : FETCH;
    end

    retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (instret)
    );
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: instruction-level randomized check of control_seq
module tb_control_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_done, halt_req, resume_req, step_req;
    logic [4:0] opcode;
    logic       write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel, rd_sel, halted, illegal;
    logic [1:0] alu_insel1, alu_insel2;
    logic [3:0] instret;

    logic       b_rst, b_mem_done;
    logic [4:0] b_opcode;
    logic       b_write_pc, b_write_ir, b_write_rd, b_mem_read, b_mem_write, b_addr_sel, b_rd_sel;
    logic       b_halted, b_illegal;
    logic [1:0] b_alu_insel1, b_alu_insel2;
    logic [7:0] b_instret;

    int n_tests = 0, n_fail = 0;
    logic [3:0] exp_instret;
    bit exp_halted, step_pending;

    control_seq #(.CNT_W(4), .HALT_ON_ILLEGAL(1), .DEBUG_EN(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_done(mem_done),
        .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
        .write_pc(write_pc), .write_ir(write_ir), .write_rd(write_rd),
        .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel), .rd_sel(rd_sel),
        .alu_insel1(alu_insel1), .alu_insel2(alu_insel2),
        .halted(halted), .illegal(illegal), .instret(instret)
    );

    control_seq #(.CNT_W(8), .HALT_ON_ILLEGAL(0), .DEBUG_EN(1)) dut_b (
        .clk(clk), .rst(b_rst), .opcode(b_opcode), .mem_done(b_mem_done),
        .halt_req(1'b0), .resume_req(1'b0), .step_req(1'b0),
        .write_pc(b_write_pc), .write_ir(b_write_ir), .write_rd(b_write_rd),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .addr_sel(b_addr_sel), .rd_sel(b_rd_sel),
        .alu_insel1(b_alu_insel1), .alu_insel2(b_alu_insel2),
        .halted(b_halted), .illegal(b_illegal), .instret(b_instret)
    );

    wire [12:0] vec_a = {write_pc, write_ir, write_rd, mem_read, mem_write, addr_sel, rd_sel,
                         alu_insel1, alu_insel2, halted, illegal};
    wire [12:0] vec_b = {b_write_pc, b_write_ir, b_write_rd, b_mem_read, b_mem_write, b_addr_sel,
                         b_rd_sel, b_alu_insel1, b_alu_insel2, b_halted, b_illegal};

    function automatic logic [12:0] mk(input bit wpc, wir, wrd, mr, mw, as, rs,
                                       input logic [1:0] i1, i2, input bit h, il);
        return {wpc, wir, wrd, mr, mw, as, rs, i1, i2, h, il};
    endfunction

    function automatic logic [12:0] fetch_vec(input bit done);
        return mk(0, done, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    endfunction

    // {write_rd, insel1, insel2} for each EXEC-class opcode
    function automatic logic [4:0] exec_exp(input logic [4:0] op);
        case (op)
            5'b01101:          return {1'b1, 2'b11, 2'b01};
            5'b00101:          return {1'b1, 2'b01, 2'b01};
            5'b11011, 5'b11001: return {1'b1, 2'b01, 2'b11};
            5'b00100:          return {1'b1, 2'b00, 2'b01};
            5'b01100:          return {1'b1, 2'b00, 2'b00};
            default:           return 5'b0;
        endcase
    endfunction

    function automatic int cls(input logic [4:0] op);
        if (op == 5'b00000) return 0;
        if (op == 5'b01000) return 1;
        if (op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                       5'b00100, 5'b01100, 5'b00011, 5'b11100}) return 2;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [12:0] e, input bit ret);
        @(negedge clk);
        check({tag, " strobes"}, 32'(vec_a), 32'(e));
        check({tag, " instret"}, 32'(instret), 32'(exp_instret));
        @(posedge clk);
        #1;
        if (ret) exp_instret = exp_instret + 4'd1;
    endtask

    task automatic rand_dbg();
        halt_req   = 1'($urandom);
        resume_req = 1'($urandom);
        step_req   = 1'($urandom);
    endtask

    task automatic run_instr(input logic [4:0] op, input int fd, md, input bit hreq);
        logic [4:0] x;
        int c;
        c = cls(op);
        x = exec_exp(op);
        opcode = op;
        for (int i = 0; i <= fd; i++) begin
            mem_done = (i == fd);
            rand_dbg();
            step("fetch", fetch_vec(i == fd), 0);
        end
        mem_done = 1'($urandom);
        rand_dbg();
        step("decode", 13'd0, 0);
        if (c == 2) begin
            mem_done = 1'($urandom);
            rand_dbg();
            halt_req = hreq;
            step("exec", mk(1, 0, x[4], 0, 0, 0, 0, x[3:2], x[1:0], 0, 0), 1);
        end else if (c == 3) begin
            mem_done = 1'($urandom);
            rand_dbg();
            step("trap", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1), 0);
        end else begin
            for (int i = 0; i <= md; i++) begin
                mem_done = (i == md);
                rand_dbg();
                if (i == md) halt_req = hreq;
                if (c == 0) step("load", mk(i == md, 0, i == md, 1, 0, 0, i == md, 2'b00, 2'b01, 0, 0), i == md);
                else        step("store", mk(i == md, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0), i == md);
            end
        end
        exp_halted   = (c == 3) || hreq || step_pending;
        step_pending = 0;
    endtask

    task automatic in_halted(input bit res, stp);
        halt_req   = 1'($urandom);
        resume_req = res;
        step_req   = stp;
        mem_done   = 1'($urandom);
        step("halted", mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0), 0);
        if (res || stp) exp_halted = 0;
        if (stp && !res) step_pending = 1;
    endtask

    logic [4:0] ops [0:10] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00100,
                               5'b01100, 5'b00011, 5'b11100, 5'b00000, 5'b01000};

    initial begin
        logic [4:0] op;
        int r;
        rst = 1; halt_req = 1; resume_req = 0; step_req = 0; mem_done = 0; opcode = 5'b00100;
        b_rst = 1; b_mem_done = 0; b_opcode = 5'b00000;
        exp_instret = 0; exp_halted = 0; step_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("reset instret", 32'(instret), 32'd0);
        check("reset halted/illegal", {30'd0, halted, illegal}, 32'd0);
        @(posedge clk);
        #1;
        run_instr(5'b00100, 3, 0, 1);
        in_halted(1, 0);
        run_instr(5'b00000, 0, 2, 0);
        run_instr(5'b01000, 1, 2, 1);
        in_halted(0, 0);
        in_halted(0, 1);
        run_instr(5'b01100, 0, 0, 0);
        in_halted(1, 1);
        run_instr(5'b11111, 0, 0, 0);
        in_halted(1, 0);
        opcode = 5'b00000; mem_done = 1; halt_req = 0; resume_req = 0; step_req = 0;
        step("rst fetch", fetch_vec(1), 0);
        mem_done = 0;
        step("rst decode", 13'd0, 0);
        step("rst load", mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0, 0), 0);
        rst = 1; mem_done = 1;
        @(posedge clk);
        #1;
        rst = 0; mem_done = 0;
        exp_instret = 0; step_pending = 0; exp_halted = 0;
        step("post-reset fetch", fetch_vec(0), 0);
        for (int k = 0; k < 80; k++) begin
            if (exp_halted) in_halted(1'($urandom), 1'($urandom));
            else begin
                r  = int'($urandom % 14);
                op = r < 11 ? ops[r] : r == 11 ? 5'b11111 : 5'($urandom);
                run_instr(op, int'($urandom % 4), int'($urandom % 4), ($urandom % 4) == 0);
            end
        end
        b_opcode = 5'b11111; b_mem_done = 1;
        @(posedge clk);
        #1;
        b_rst = 0;
        @(negedge clk);
        check("b fetch", 32'(vec_b), 32'(fetch_vec(1)));
        @(posedge clk);
        #1;
        b_mem_done = 0;
        @(negedge clk);
        check("b decode", 32'(vec_b), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b trap", 32'(vec_b), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1)));
        check("b trap instret", 32'(b_instret), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b after trap", 32'(vec_b), 32'(fetch_vec(0)));
        check("b final instret", 32'(b_instret), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
